// File: rtl/pc_pkg.sv
// Shared types and sizing for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned PC_W_DEFAULT = 10;
  localparam int unsigned LUT_DEPTH    = 16;
  localparam int unsigned LUT_IDX_W    = $clog2(LUT_DEPTH);
  localparam int unsigned CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    DONE    = 2'd3
  } pc_state_e;

endpackage

// File: rtl/branch_lut.sv
// Branch target ROM: maps the 4-bit instruction immediate to an absolute PC.
// Program-specific target constants live only in this file.
module branch_lut
  import pc_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [PC_W-1:0]      target_o
);

  always_comb begin
    target_o = '0;
    unique case (idx_i)
      4'd0:  target_o = PC_W'(0);
      4'd1:  target_o = PC_W'(8);
      4'd2:  target_o = PC_W'(16);
      4'd3:  target_o = PC_W'(24);
      4'd4:  target_o = PC_W'(32);
      4'd5:  target_o = PC_W'(40);
      4'd6:  target_o = PC_W'(48);
      4'd7:  target_o = PC_W'(56);
      4'd8:  target_o = PC_W'(64);
      4'd9:  target_o = PC_W'(72);
      4'd10: target_o = PC_W'(80);
      4'd11: target_o = PC_W'(88);
      4'd12: target_o = PC_W'(96);
      4'd13: target_o = PC_W'(104);
      4'd14: target_o = PC_W'(112);
      4'd15: target_o = '1;  // last entry always reaches the top of PC space
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: start/halt, branch redirect via LUT, memory stalls.
// Define BRANCH_COUNT_EN to add the saturating taken-branch counter output.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEFAULT,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 branch_en,
  input  logic                 notequal,
  input  logic                 lessthan,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 mem_req,
  input  logic                 halt_req,
  output logic [PC_W-1:0]      prog_ctr,
  output logic                 instr_valid,
  output logic                 stall,
  output logic                 done
`ifdef BRANCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]     taken_cnt
`endif
);

  localparam int unsigned        WAIT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_INIT = WAIT_W'(MEM_WAIT - 1);
  localparam bit                 STALL_EN  = (MEM_WAIT > 0);

  pc_state_e         state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              iv_q, stall_q, done_q;
  logic [PC_W-1:0]   lut_tgt;

  branch_lut #(.PC_W(PC_W)) u_lut (
    .idx_i    (lut_idx),
    .target_o (lut_tgt)
  );

  // Next-state and next-PC decode; priority in RUN is halt > stall > branch > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_d = DONE;
        end else if (mem_req && STALL_EN) begin
          state_d = MEMWAIT;
          wait_d  = WAIT_INIT;
        end else if (branch_en && (notequal || lessthan)) begin
          pc_d = lut_tgt;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      MEMWAIT: begin
        if (wait_q == '0) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = RUN;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      DONE: begin
        if (start) begin
          pc_d    = '0;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wait_q  <= '0;
      iv_q    <= 1'b0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      iv_q    <= (state_d == RUN);
      stall_q <= (state_d == MEMWAIT);
      done_q  <= (state_d == DONE);
    end
  end

  assign prog_ctr    = pc_q;
  assign instr_valid = iv_q;
  assign stall       = stall_q;
  assign done        = done_q;

`ifdef BRANCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_taken, start_ok;

  // A branch only counts when it actually redirects the PC.
  always_comb begin
    br_taken = (state_q == RUN) && !halt_req && !(mem_req && STALL_EN) &&
               branch_en && (notequal || lessthan);
    start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    cnt_d    = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (br_taken && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign taken_cnt = cnt_q;
`endif

endmodule
